// File: rtl/fir_fold_ctrl.sv
// Sequencer for a folded FIR: clears the sample RAM, writes each sample into a
// circular buffer, steps one MAC per tap, waits out the MAC latency, then hands off the result.
module fir_fold_ctrl #(
  parameter int TAP_COUNT  = 36,
  parameter int ADDR_WIDTH = 6,
  parameter int MAC_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  smp_we,
  output logic                  smp_zero,
  output logic [ADDR_WIDTH-1:0] smp_waddr,
  output logic [ADDR_WIDTH-1:0] smp_raddr,
  output logic [ADDR_WIDTH-1:0] coef_raddr,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  mac_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HOLD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TAP_COUNT - 1);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] k;
  logic [DW-1:0]         drain_cnt;

  // Write port and input handshake depend only on the current state, so a sample lands the cycle it is offered
  assign in_ready  = (state == S_IDLE);
  assign smp_we    = (state == S_CLEAR) || ((state == S_IDLE) && in_valid);
  assign smp_zero  = (state == S_CLEAR);
  assign smp_waddr = (state == S_CLEAR) ? clr_cnt : wr_ptr;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      wr_ptr     <= '0;
      k          <= '0;
      drain_cnt  <= '0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      mac_last   <= 1'b0;
      out_valid  <= 1'b0;
      smp_raddr  <= '0;
      coef_raddr <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (in_valid) begin
            wr_ptr     <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            k          <= '0;
            state      <= S_RUN;
            mac_en     <= 1'b1;
            mac_clr    <= 1'b1;
            mac_last   <= 1'b0;
            coef_raddr <= '0;
            // The newest sample is the one being written right now
            smp_raddr  <= wr_ptr;
          end
        end

        S_RUN: begin
          if (k == LAST_ADDR) begin
            k         <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            mac_last  <= 1'b0;
            drain_cnt <= '0;
            if (MAC_LAT == 0) begin
              state     <= S_HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            k          <= k + 1'b1;
            coef_raddr <= k + 1'b1;
            smp_raddr  <= (smp_raddr == '0) ? LAST_ADDR : smp_raddr - 1'b1;
            mac_clr    <= 1'b0;
            mac_last   <= ((k + 1'b1) == LAST_ADDR);
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= S_HOLD;
            out_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Directed self-checking bench for fir_fold_ctrl with TAP_COUNT=36, MAC_LAT=2.
module tb_fir_fold_ctrl;

  localparam int TAPS = 36;
  localparam int AW   = 6;
  localparam int LAT  = 2;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic          smp_we;
  logic          smp_zero;
  logic [AW-1:0] smp_waddr;
  logic [AW-1:0] smp_raddr;
  logic [AW-1:0] coef_raddr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fir_fold_ctrl #(.TAP_COUNT(TAPS), .ADDR_WIDTH(AW), .MAC_LAT(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .smp_we     (smp_we),
    .smp_zero   (smp_zero),
    .smp_waddr  (smp_waddr),
    .smp_raddr  (smp_raddr),
    .coef_raddr (coef_raddr),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .mac_last   (mac_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expects to start on the first CLEAR cycle; ends on the first IDLE cycle
  task automatic clear_phase();
    for (int i = 0; i < TAPS; i++) begin
      check_output($sformatf("clr_we%0d", i), 32'(smp_we), 1);
      check_output($sformatf("clr_zero%0d", i), 32'(smp_zero), 1);
      check_output($sformatf("clr_waddr%0d", i), 32'(smp_waddr), i);
      check_output($sformatf("clr_rdy%0d", i), 32'(in_ready), 0);
      check_output($sformatf("clr_mac%0d", i), 32'(mac_en), 0);
      tick();
    end
    check_output("idle_rdy", 32'(in_ready), 1);
    check_output("idle_busy", 32'(busy), 0);
    check_output("idle_zero", 32'(smp_zero), 0);
  endtask

  task automatic apply_stimulus(input int exp_waddr, input bit pulse, input int hold_extra,
                                input bit overlap);
    int exp_r;
    check_output("acc_rdy", 32'(in_ready), 1);
    in_valid = 1'b1;
    #1;
    check_output("acc_we", 32'(smp_we), 1);
    check_output("acc_zero", 32'(smp_zero), 0);
    check_output("acc_waddr", 32'(smp_waddr), exp_waddr);
    tick();
    for (int k = 0; k < TAPS; k++) begin
      in_valid = pulse && (k == 5 || k == 6);
      #1;
      exp_r = (exp_waddr - k + TAPS) % TAPS;
      check_output($sformatf("run_en%0d", k), 32'(mac_en), 1);
      check_output($sformatf("run_coef%0d", k), 32'(coef_raddr), k);
      check_output($sformatf("run_raddr%0d", k), 32'(smp_raddr), exp_r);
      check_output($sformatf("run_clr%0d", k), 32'(mac_clr), (k == 0) ? 1 : 0);
      check_output($sformatf("run_last%0d", k), 32'(mac_last), (k == TAPS - 1) ? 1 : 0);
      check_output($sformatf("run_rdy%0d", k), 32'(in_ready), 0);
      check_output($sformatf("run_we%0d", k), 32'(smp_we), 0);
      check_output($sformatf("run_ov%0d", k), 32'(out_valid), 0);
      tick();
    end
    in_valid = 1'b0;
    for (int d = 0; d < LAT; d++) begin
      check_output($sformatf("drain_en%0d", d), 32'(mac_en), 0);
      check_output($sformatf("drain_ov%0d", d), 32'(out_valid), 0);
      check_output($sformatf("drain_we%0d", d), 32'(smp_we), 0);
      tick();
    end
    check_output("hold_ov_first", 32'(out_valid), 1);
    for (int h = 0; h < hold_extra; h++) begin
      check_output($sformatf("hold_ov%0d", h), 32'(out_valid), 1);
      check_output($sformatf("hold_rdy%0d", h), 32'(in_ready), 0);
      check_output($sformatf("hold_en%0d", h), 32'(mac_en), 0);
      check_output($sformatf("hold_busy%0d", h), 32'(busy), 1);
      tick();
    end
    out_ready = 1'b1;
    if (overlap) in_valid = 1'b1;
    #1;
    check_output("hs_ov", 32'(out_valid), 1);
    check_output("hs_we", 32'(smp_we), 0);
    tick();
    out_ready = 1'b0;
    check_output("post_ov", 32'(out_valid), 0);
    check_output("post_rdy", 32'(in_ready), 1);
    if (overlap) check_output("post_overlap_we", 32'(smp_we), 1);
  endtask

  initial begin
    int seen;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_output("rst_mac_en", 32'(mac_en), 0);
    check_output("rst_mac_clr", 32'(mac_clr), 0);
    check_output("rst_mac_last", 32'(mac_last), 0);
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_raddr", 32'(smp_raddr), 0);
    check_output("rst_coef", 32'(coef_raddr), 0);
    check_output("rst_rdy", 32'(in_ready), 0);
    check_output("rst_busy", 32'(busy), 1);

    reset_n = 1'b1;
    clear_phase();

    // Sample 1 sees an in_valid pulse mid-run, sample 2 waits 10 cycles in HOLD,
    // sample 3 gets in_valid together with the output handshake; sample 36 wraps to address 0
    for (int i = 0; i <= TAPS; i++)
      apply_stimulus(i % TAPS, (i == 1), (i == 2) ? 10 : 0, (i == 3));

    in_valid = 1'b1;
    #1;
    check_output("abort_waddr", 32'(smp_waddr), 1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check_output("abort_k10_coef", 32'(coef_raddr), 10);
    check_output("abort_k10_raddr", 32'(smp_raddr), (1 - 10 + TAPS) % TAPS);
    check_output("abort_k10_en", 32'(mac_en), 1);
    reset_n = 1'b0;
    #1;
    check_output("abort_en", 32'(mac_en), 0);
    check_output("abort_clr", 32'(mac_clr), 0);
    check_output("abort_last", 32'(mac_last), 0);
    check_output("abort_ov", 32'(out_valid), 0);
    check_output("abort_coef", 32'(coef_raddr), 0);
    check_output("abort_raddr", 32'(smp_raddr), 0);
    check_output("abort_rdy", 32'(in_ready), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    clear_phase();

    seen = 0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid !== 1'b0 || mac_en !== 1'b0) seen++;
      tick();
    end
    check_output("abort_no_result", 32'(seen), 0);

    apply_stimulus(0, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_fold_ctrl.md
Name: fir_fold_ctrl

Overview:
- Sequencer for a time-multiplexed (folded) FIR datapath. One shared multiplier/accumulator, an external TAP_COUNT-deep sample RAM and an external coefficient ROM do the work of a fully parallel TAP_COUNT-tap filter.
- Per accepted input sample, the block:
  - writes the sample into a circular buffer;
  - issues TAP_COUNT read/MAC steps;
  - waits out the MAC latency;
  - presents a valid/ready result strobe.
- Sits between the sample source and the shared MAC/accumulator datapath. After reset, it clears the sample RAM so the first outputs see zero history.

Parameters:
TAP_COUNT, 36, number of filter taps = sample RAM depth = coefficient count (>=2)
ADDR_WIDTH, 6, width of RAM/ROM addresses; 2**ADDR_WIDTH >= TAP_COUNT
MAC_LAT, 2, cycles from the last mac_en to the accumulator result being valid (>=0)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  new input sample available
in_ready  output  1  controller accepts a sample this cycle
smp_we  output  1  sample RAM write enable
smp_zero  output  1  when 1, RAM writes 0 instead of data_in (clear phase)
smp_waddr  output  ADDR_WIDTH  sample RAM write address
smp_raddr  output  ADDR_WIDTH  sample RAM read address
coef_raddr  output  ADDR_WIDTH  coefficient ROM read address
mac_en  output  1  MAC consumes the current sample*coef product
mac_clr  output  1  with mac_en: load the product instead of accumulating
mac_last  output  1  marks the final tap step
out_valid  output  1  accumulator holds a finished result
out_ready  input  1  downstream takes the result
busy  output  1  state != IDLE

Behaviour:
- Reset and clocking:
  - Reset reset_n, asynchronous, active-low; clock clk.
  - During reset: state=CLEAR, clear counter=0, wr_ptr=0, tap counter k=0.
  - All registered outputs reset to 0: mac_en, mac_clr, mac_last, out_valid, smp_raddr, coef_raddr.
- States: CLEAR, IDLE, RUN, DRAIN, HOLD.
- CLEAR:
  - For TAP_COUNT cycles: smp_we=1, smp_zero=1, smp_waddr=clear counter, counting 0..TAP_COUNT-1.
  - in_ready=0; then go to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: smp_we=1, smp_zero=0, smp_waddr=wr_ptr, all combinational in the same cycle.
  - Latch newest=wr_ptr. wr_ptr advances by 1, wrapping TAP_COUNT-1 -> 0.
  - Go to RUN with k=0.
- RUN:
  - Lasts exactly TAP_COUNT cycles, k=0..TAP_COUNT-1. in_ready=0.
  - Outputs are registered, so each output cycle carries the step-k values:
    - mac_en=1;
    - coef_raddr=k;
    - smp_raddr=(newest-k) mod TAP_COUNT, a decrementing pointer wrapping 0 -> TAP_COUNT-1;
    - mac_clr=1 only for k=0;
    - mac_last=1 only for k=TAP_COUNT-1.
  - After the last step, go to DRAIN, or straight to HOLD if MAC_LAT=0.
- DRAIN: MAC_LAT cycles with mac_en=0, then go to HOLD.
- HOLD:
  - out_valid=1, held stable until out_ready=1.
  - On the handshake cycle, go to IDLE; out_valid=0 the next cycle.
- Timing, with the accept edge at cycle T:
  - mac_en high in cycles T+1..T+TAP_COUNT;
  - out_valid first high at T+TAP_COUNT+MAC_LAT+1;
  - minimum sample period = TAP_COUNT+MAC_LAT+2 cycles.
- Boundaries:
  - in_valid outside IDLE is ignored: no write, wr_ptr unchanged.
  - in_valid and out_ready together in HOLD: only the output handshake completes. The sample is accepted in the next IDLE cycle if in_valid is still high.
  - wr_ptr wrap: the sample after address TAP_COUNT-1 writes address 0.
  - Reset asserted mid-RUN/DRAIN/HOLD aborts immediately: no out_valid, and the full CLEAR sequence reruns.
  - mac_en is never high outside RUN; smp_we is never high outside CLEAR/IDLE.

Test Plan:
- Release reset -> 36 cycles smp_we=1, smp_zero=1, smp_waddr 0..35; in_ready=0; in_ready=1 on the 37th cycle.
- One sample accepted at T with wr_ptr=0:
  - smp_waddr=0;
  - T+1..T+36: coef_raddr 0..35, smp_raddr 0,35,34..1;
  - mac_clr only at T+1, mac_last only at T+36;
  - out_valid at T+39.
- 37th sample -> smp_waddr=0; smp_raddr sequence 0,35,34,...,1.
- Hold out_ready=0 for 10 cycles in HOLD -> out_valid stays 1, in_ready stays 0, no mac_en; raise out_ready -> IDLE, in_ready=1 next cycle.
- Pulse in_valid during RUN -> no smp_we, wr_ptr unchanged, the later result's smp_raddr sequence is unaffected.
- Assert reset_n=0 at RUN step k=10 -> outputs 0 immediately; after release, full 36-cycle CLEAR, and out_valid never asserts for the aborted sample.
